// File: rtl/conn_setup_parser_if.sv
// conn_setup_parser_if: setup-frame input bus and connection-manager request bus
interface conn_setup_parser_if #(
   parameter int NUM_FIELDS = 8,
   parameter int DATA_W = 32,
   parameter int CMD_W = 4
);
   logic frame_valid_in;
   logic [CMD_W-1:0] frame_cmd_in;
   logic [DATA_W-1:0] frame_data_in;
   logic frame_ready_out;
   logic cm_valid_out;
   logic cm_ready_in;
   logic [NUM_FIELDS*DATA_W-1:0] cm_fields_out;
   logic cm_open_out;
   modport master (
      output frame_valid_in, frame_cmd_in, frame_data_in, cm_ready_in,
      input frame_ready_out, cm_valid_out, cm_fields_out, cm_open_out
   );
   modport slave (
      input frame_valid_in, frame_cmd_in, frame_data_in, cm_ready_in,
      output frame_ready_out, cm_valid_out, cm_fields_out, cm_open_out
   );
endinterface

// File: rtl/conn_setup_parser.sv
// conn_setup_parser: collects setup fields from frames and issues open/close requests to the connection manager
module conn_setup_parser #(
   parameter int NUM_FIELDS = 8,
   parameter int DATA_W = 32,
   parameter int CMD_W = 4,
   parameter logic [NUM_FIELDS-1:0] OPEN_MASK = '1,
   parameter logic [NUM_FIELDS-1:0] CLOSE_MASK = NUM_FIELDS'(1),
   parameter int TIMEOUT = 1024
) (
   input logic clk,
   input logic reset,
   conn_setup_parser_if.slave bus,
   output logic busy_out,
   output logic err_valid_out,
   output logic [1:0] err_code_out,
   input logic err_clear_in,
   output logic [15:0] setup_count_out
);
   localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, ISSUE = 2'd2, ERROR = 2'd3;
   localparam int TW = $clog2(TIMEOUT + 2);
   logic [1:0] state;
   logic [NUM_FIELDS-1:0] written;
   logic [NUM_FIELDS-1:0][DATA_W-1:0] fld;
   logic [TW-1:0] idle_cnt;
   logic take, is_field, is_en, open_req, timed_out;
   logic [NUM_FIELDS-1:0] req;
   assign bus.frame_ready_out = state != ISSUE;
   assign busy_out = state != IDLE;
   assign take = bus.frame_valid_in && (state == IDLE || state == COLLECT);
   assign is_field = bus.frame_cmd_in < CMD_W'(NUM_FIELDS);
   assign is_en = bus.frame_cmd_in == CMD_W'(NUM_FIELDS);
   assign open_req = written[1] && fld[1][0];
   assign req = open_req ? OPEN_MASK : CLOSE_MASK;
   assign timed_out = TIMEOUT != 0 && state == COLLECT && !bus.frame_valid_in && idle_cnt == TW'(TIMEOUT - 1);
   // idle-cycle counter, only live while collecting and cleared by every accepted frame
   always_ff @(posedge clk) begin
      idle_cnt <= (reset || state != COLLECT || take) ? '0 : idle_cnt + TW'(1);
   end
   // frame acceptance, field capture, request issue and sticky first-error tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         written <= '0;
         fld <= '0;
         bus.cm_valid_out <= 1'b0;
         bus.cm_fields_out <= '0;
         bus.cm_open_out <= 1'b0;
         err_valid_out <= 1'b0;
         err_code_out <= 2'd0;
         setup_count_out <= 16'd0;
      end else if (take && is_field) begin
         for (int i = 0; i < NUM_FIELDS; i++)
            if (bus.frame_cmd_in == CMD_W'(i)) begin
               fld[i] <= bus.frame_data_in;
               written[i] <= 1'b1;
            end
         state <= COLLECT;
      end else if (take && is_en && (written & req) == req) begin
         state <= ISSUE;
         bus.cm_valid_out <= 1'b1;
         bus.cm_fields_out <= fld;
         bus.cm_open_out <= open_req;
      end else if (take || timed_out) begin
         state <= ERROR;
         err_valid_out <= 1'b1;
         err_code_out <= !take ? 2'd3 : is_en ? 2'd1 : 2'd2;
      end else if (state == ISSUE && bus.cm_ready_in) begin
         state <= IDLE;
         written <= '0;
         bus.cm_valid_out <= 1'b0;
         setup_count_out <= setup_count_out == 16'hFFFF ? setup_count_out : setup_count_out + 16'd1;
      end else if (state == ERROR && err_clear_in) begin
         state <= IDLE;
         written <= '0;
         err_valid_out <= 1'b0;
         err_code_out <= 2'd0;
      end
   end
endmodule

// File: tb/tb_conn_setup_parser.sv
// tb_conn_setup_parser: scoreboard bench for request issue, errors, timeout, backpressure, reset and saturation
module tb_conn_setup_parser;
   localparam int NF = 8, DW = 32, CW = 4, FW = NF * DW;
   localparam logic [CW-1:0] EN = CW'(NF);
   typedef struct packed {
      logic [FW-1:0] f;
      logic o;
   } req_t;
   logic clk = 1'b0, reset = 1'b1, err_clear_in = 1'b0;
   logic busy_out, err_valid_out;
   logic [1:0] err_code_out;
   logic [15:0] setup_count_out;
   logic [FW-1:0] mvec = '0;
   req_t exp_q[$];
   int n_cmp = 0, n_bad = 0, hs_cnt = 0, exp_hs = 0;
   conn_setup_parser_if #(.NUM_FIELDS(NF), .DATA_W(DW), .CMD_W(CW)) bus ();
   conn_setup_parser #(.NUM_FIELDS(NF), .DATA_W(DW), .CMD_W(CW), .TIMEOUT(16)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .busy_out(busy_out),
      .err_valid_out(err_valid_out),
      .err_code_out(err_code_out),
      .err_clear_in(err_clear_in),
      .setup_count_out(setup_count_out)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic raw(input logic [CW-1:0] cmd, input logic [DW-1:0] d);
      bus.frame_valid_in = 1'b1;
      bus.frame_cmd_in = cmd;
      bus.frame_data_in = d;
      tick();
      bus.frame_valid_in = 1'b0;
   endtask
   task automatic wr(input int k, input logic [DW-1:0] d);
      mvec[k*DW +: DW] = d;
      raw(CW'(k), d);
   endtask
   task automatic en_ok(input logic o);
      exp_q.push_back({mvec, o});
      exp_hs++;
      raw(EN, '0);
   endtask
   task automatic wait_hs();
      for (int i = 0; i < 20 && hs_cnt < exp_hs; i++) tick();
      check("hs_count", FW'(hs_cnt), FW'(exp_hs));
   endtask
   task automatic clear_err();
      err_clear_in = 1'b1;
      tick();
      err_clear_in = 1'b0;
   endtask
   task automatic chk_err(input string tag, input logic v, input logic [1:0] c);
      @(negedge clk);
      check({tag, "_valid"}, FW'(err_valid_out), FW'(v));
      check({tag, "_code"}, FW'(err_code_out), FW'(c));
   endtask
   // scoreboard: every request handshake is matched against the oldest expected request
   always @(negedge clk) begin
      if (!reset && bus.cm_valid_out && bus.cm_ready_in) begin
         if (exp_q.size() == 0) check("hs_unexpected", FW'(1), FW'(0));
         else begin
            req_t e;
            e = exp_q.pop_front();
            check("hs_fields", bus.cm_fields_out, e.f);
            check("hs_open", FW'(bus.cm_open_out), FW'(e.o));
         end
         hs_cnt++;
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      bus.frame_valid_in = 1'b0;
      bus.frame_cmd_in = '0;
      bus.frame_data_in = '0;
      bus.cm_ready_in = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_cm_valid", FW'(bus.cm_valid_out), FW'(0));
      check("rst_fields", bus.cm_fields_out, FW'(0));
      check("rst_open", FW'(bus.cm_open_out), FW'(0));
      check("rst_err", FW'({err_valid_out, err_code_out}), FW'(0));
      check("rst_count", FW'(setup_count_out), FW'(0));
      check("rst_busy", FW'(busy_out), FW'(0));
      check("rst_ready", FW'(bus.frame_ready_out), FW'(1));
      tick();
      reset = 1'b0;
      // open request with every field written
      for (int k = 0; k < NF; k++) wr(k, k == 1 ? 32'd1 : {16'hC0DE, 16'(k * 17 + 3)});
      en_ok(1'b1);
      @(negedge clk);
      check("open_lat_valid", FW'(bus.cm_valid_out), FW'(1));
      check("open_lat_open", FW'(bus.cm_open_out), FW'(1));
      check("open_fields", bus.cm_fields_out, mvec);
      tick();
      check("open_one_cycle", FW'(bus.cm_valid_out), FW'(0));
      check("open_idle", FW'(busy_out), FW'(0));
      check("open_count", FW'(setup_count_out), FW'(1));
      wait_hs();
      // close request: field 1 still holds 1 but is no longer written, so open reads 0
      wr(0, 32'd5);
      en_ok(1'b0);
      wait_hs();
      check("close_count", FW'(setup_count_out), FW'(2));
      wr(1, 32'd1);
      raw(EN, '0);
      chk_err("missing", 1'b1, 2'd1);
      check("missing_no_req", FW'(bus.cm_valid_out), FW'(0));
      bus.frame_valid_in = 1'b1;
      bus.frame_cmd_in = 4'd0;
      bus.frame_data_in = 32'hDEAD;
      clear_err();
      bus.frame_valid_in = 1'b0;
      chk_err("clear", 1'b0, 2'd0);
      check("clear_idle", FW'(busy_out), FW'(0));
      raw(EN, '0);
      chk_err("clear_discard", 1'b1, 2'd1);
      clear_err();
      // backpressure: request and fields held, frames refused
      bus.cm_ready_in = 1'b0;
      wr(0, 32'd7);
      wr(1, 32'd0);
      en_ok(1'b0);
      bus.frame_valid_in = 1'b1;
      bus.frame_cmd_in = 4'd0;
      bus.frame_data_in = 32'hBAD;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", FW'(bus.cm_valid_out), FW'(1));
         check("bp_fields", bus.cm_fields_out, mvec);
         check("bp_ready", FW'(bus.frame_ready_out), FW'(0));
         tick();
      end
      bus.frame_valid_in = 1'b0;
      bus.cm_ready_in = 1'b1;
      wait_hs();
      tick();
      check("bp_single", FW'(hs_cnt), FW'(exp_hs));
      check("bp_count", FW'(setup_count_out), FW'(3));
      // invalid command, then first error wins
      raw(CW'(NF + 1), '0);
      chk_err("invalid", 1'b1, 2'd2);
      repeat (20) tick();
      raw(4'd0, 32'd1);
      raw(EN, '0);
      raw(4'd15, '0);
      chk_err("first_wins", 1'b1, 2'd2);
      clear_err();
      chk_err("inv_clear", 1'b0, 2'd0);
      check("inv_idle", FW'(busy_out), FW'(0));
      // timeout after 16 idle cycles, not after 15
      wr(0, 32'd11);
      repeat (15) tick();
      chk_err("to_15", 1'b0, 2'd0);
      tick();
      chk_err("to_16", 1'b1, 2'd3);
      clear_err();
      wr(0, 32'd12);
      for (int r = 0; r < 4; r++) begin
         repeat (14) tick();
         wr(0, 32'd13 + 32'(r));
      end
      repeat (14) tick();
      chk_err("to_keepalive", 1'b0, 2'd0);
      en_ok(1'b0);
      wait_hs();
      check("to_count", FW'(setup_count_out), FW'(4));
      // reset while a request is pending
      bus.cm_ready_in = 1'b0;
      for (int k = 0; k < NF; k++) wr(k, k == 1 ? 32'd1 : 32'(k + 100));
      raw(EN, '0);
      @(negedge clk);
      check("prerst_valid", FW'(bus.cm_valid_out), FW'(1));
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mvec = '0;
      @(negedge clk);
      check("issrst_valid", FW'(bus.cm_valid_out), FW'(0));
      check("issrst_fields", bus.cm_fields_out, FW'(0));
      check("issrst_open", FW'(bus.cm_open_out), FW'(0));
      check("issrst_count", FW'(setup_count_out), FW'(0));
      check("issrst_busy", FW'(busy_out), FW'(0));
      // saturation of the completed-request counter
      bus.cm_ready_in = 1'b1;
      tick();
      force dut.setup_count_out = 16'hFFFF;
      tick();
      release dut.setup_count_out;
      wr(0, 32'd9);
      en_ok(1'b0);
      wait_hs();
      tick();
      check("sat_count", FW'(setup_count_out), FW'(16'hFFFF));
      check("sb_empty", FW'(exp_q.size()), FW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
